// File: rtl/regfile_arb_pkg.sv
// Shared types and default widths for the register file arbiter.
package regfile_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_DBG  = 2'd2
    } owner_e;

    localparam int ADDR_W = 3;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 8;

endpackage

// File: rtl/regfile_arb_pick.sv
// Combinational next-owner selection for the register file arbiter.
// REGFILE_ARB_ROUND_ROBIN_EN selects round-robin contention; default is core over debug.
module regfile_arb_pick
    import regfile_arb_pkg::*;
(
    input  logic   core_req_i,
    input  logic   dbg_req_i,
    input  logic   core_lock_i,
    input  logic   dbg_lock_i,
    input  owner_e owner_i,
    input  owner_e last_i,
    output owner_e next_o,
    output logic   contended_o
);

    logic core_cand;
    logic dbg_cand;

    always_comb begin
        next_o    = OWN_NONE;
        // the current owner sits out one edge unless it holds a lock
        core_cand = core_req_i && (owner_i != OWN_CORE);
        dbg_cand  = dbg_req_i && (owner_i != OWN_DBG);
        if (owner_i == OWN_CORE && core_lock_i && core_req_i) begin
            next_o = OWN_CORE;
        end else if (owner_i == OWN_DBG && dbg_lock_i && dbg_req_i) begin
            next_o = OWN_DBG;
        end else if (core_cand && dbg_cand) begin
`ifdef REGFILE_ARB_ROUND_ROBIN_EN
            next_o = (last_i == OWN_CORE) ? OWN_DBG : OWN_CORE;
`else
            next_o = OWN_CORE;
`endif
        end else if (core_cand) begin
            next_o = OWN_CORE;
        end else if (dbg_cand) begin
            next_o = OWN_DBG;
        end
    end

    // only one owner can be picked, so two live requests always leave one waiting
    assign contended_o = core_req_i && dbg_req_i;

`ifndef REGFILE_ARB_ROUND_ROBIN_EN
    logic unused_last;
    assign unused_last = ^last_i;
`endif

endmodule

// File: rtl/regfile_arbiter.sv
// Arbitrates the register file port between the core path and the debug port.
// Define REGFILE_ARB_ROUND_ROBIN_EN for round-robin contention instead of core priority.
module regfile_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int ADDR_W = regfile_arb_pkg::ADDR_W,
    parameter int DATA_W = regfile_arb_pkg::DATA_W,
    parameter int CNT_W  = regfile_arb_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              halt,
    input  logic              core_req,
    input  logic              dbg_req,
    input  logic              core_lock,
    input  logic              dbg_lock,
    input  logic              core_we,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] core_wdata,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              core_gnt,
    output logic              dbg_gnt,
    output logic [DATA_W-1:0] core_rdata,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              core_rvalid,
    output logic              dbg_rvalid,
    output logic [ADDR_W-1:0] rf_addr,
    output logic              rf_we,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic [CNT_W-1:0]  conflict_cnt
);

    owner_e            owner_q, owner_d;
    owner_e            last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] core_rdata_q, core_rdata_d;
    logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
    logic              core_rvalid_q, core_rvalid_d;
    logic              dbg_rvalid_q, dbg_rvalid_d;
    logic              core_eff;
    logic              contended;

    assign core_eff = core_req && !halt;

    regfile_arb_pick u_pick (
        .core_req_i  (core_eff),
        .dbg_req_i   (dbg_req),
        .core_lock_i (core_lock),
        .dbg_lock_i  (dbg_lock),
        .owner_i     (owner_q),
        .last_i      (last_q),
        .next_o      (owner_d),
        .contended_o (contended)
    );

    always_comb begin
        last_d        = (owner_d != OWN_NONE) ? owner_d : last_q;
        cnt_d         = (contended && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
        core_rvalid_d = (owner_q == OWN_CORE) && !core_we;
        dbg_rvalid_d  = (owner_q == OWN_DBG) && !dbg_we;
        core_rdata_d  = core_rvalid_d ? rf_rdata : core_rdata_q;
        dbg_rdata_d   = dbg_rvalid_d ? rf_rdata : dbg_rdata_q;
    end

    // port mux follows the registered owner so reset kills a write immediately
    always_comb begin
        rf_we    = 1'b0;
        rf_addr  = '0;
        rf_wdata = '0;
        case (owner_q)
            OWN_CORE: begin
                rf_we    = core_we;
                rf_addr  = core_addr;
                rf_wdata = core_wdata;
            end
            OWN_DBG: begin
                rf_we    = dbg_we;
                rf_addr  = dbg_addr;
                rf_wdata = dbg_wdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q       <= OWN_NONE;
            last_q        <= OWN_DBG;
            cnt_q         <= '0;
            core_rdata_q  <= '0;
            dbg_rdata_q   <= '0;
            core_rvalid_q <= 1'b0;
            dbg_rvalid_q  <= 1'b0;
        end else begin
            owner_q       <= owner_d;
            last_q        <= last_d;
            cnt_q         <= cnt_d;
            core_rdata_q  <= core_rdata_d;
            dbg_rdata_q   <= dbg_rdata_d;
            core_rvalid_q <= core_rvalid_d;
            dbg_rvalid_q  <= dbg_rvalid_d;
        end
    end

    assign core_gnt     = (owner_q == OWN_CORE);
    assign dbg_gnt      = (owner_q == OWN_DBG);
    assign core_rdata   = core_rdata_q;
    assign dbg_rdata    = dbg_rdata_q;
    assign core_rvalid  = core_rvalid_q;
    assign dbg_rvalid   = dbg_rvalid_q;
    assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Self-checking bench for regfile_arbiter: directed scenarios plus randomized traffic
// against a behavioural model of owners, register contents and the conflict count.
module tb_regfile_arbiter;

    localparam int AW = 3;
    localparam int DW = 8;
    localparam int CW = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          halt = 1'b0;
    logic          core_req = 1'b0, dbg_req = 1'b0;
    logic          core_lock = 1'b0, dbg_lock = 1'b0;
    logic          core_we = 1'b0, dbg_we = 1'b0;
    logic [AW-1:0] core_addr = '0, dbg_addr = '0;
    logic [DW-1:0] core_wdata = '0, dbg_wdata = '0;
    logic          core_gnt, dbg_gnt, core_rvalid, dbg_rvalid, rf_we;
    logic [DW-1:0] core_rdata, dbg_rdata, rf_wdata, rf_rdata;
    logic [AW-1:0] rf_addr;
    logic [CW-1:0] conflict_cnt;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    regfile_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .halt(halt),
        .core_req(core_req), .dbg_req(dbg_req),
        .core_lock(core_lock), .dbg_lock(dbg_lock),
        .core_we(core_we), .dbg_we(dbg_we),
        .core_addr(core_addr), .dbg_addr(dbg_addr),
        .core_wdata(core_wdata), .dbg_wdata(dbg_wdata),
        .core_gnt(core_gnt), .dbg_gnt(dbg_gnt),
        .core_rdata(core_rdata), .dbg_rdata(dbg_rdata),
        .core_rvalid(core_rvalid), .dbg_rvalid(dbg_rvalid),
        .rf_addr(rf_addr), .rf_we(rf_we), .rf_wdata(rf_wdata),
        .rf_rdata(rf_rdata), .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    // register file driven by the DUT's port
    logic [DW-1:0] phys [8];
    assign rf_rdata = phys[rf_addr];
    always @(posedge clk) if (rf_we) phys[rf_addr] <= rf_wdata;

    // behavioural model: 0 = nobody, 1 = core, 2 = debug
    int            mown = 0, mlast = 2, mcnt = 0, m_nxt = 0;
    logic [DW-1:0] mreg [8];
    logic [DW-1:0] m_crd = '0, m_drd = '0;
    logic          m_crv = 1'b0, m_drv = 1'b0, m_cdone = 1'b0, m_ddone = 1'b0;
    logic          m_ec, m_ed, m_cc, m_dc;

    task automatic model_step();
        if (reset) begin
            mown = 0; mlast = 2; mcnt = 0;
            m_crd = '0; m_drd = '0; m_crv = 1'b0; m_drv = 1'b0;
            m_cdone = 1'b0; m_ddone = 1'b0;
        end else begin
            m_ec = core_req && !halt;
            m_ed = dbg_req;
            m_cdone = (mown == 1);
            m_ddone = (mown == 2);
            m_crv = 1'b0;
            m_drv = 1'b0;
            if (mown == 1) begin
                if (core_we) mreg[core_addr] = core_wdata;
                else begin m_crd = mreg[core_addr]; m_crv = 1'b1; end
            end else if (mown == 2) begin
                if (dbg_we) mreg[dbg_addr] = dbg_wdata;
                else begin m_drd = mreg[dbg_addr]; m_drv = 1'b1; end
            end
            m_cc = m_ec && mown != 1;
            m_dc = m_ed && mown != 2;
            if (mown == 1 && core_lock && m_ec) m_nxt = 1;
            else if (mown == 2 && dbg_lock && m_ed) m_nxt = 2;
            else if (m_cc && m_dc) begin
`ifdef REGFILE_ARB_ROUND_ROBIN_EN
                m_nxt = (mlast == 1) ? 2 : 1;
`else
                m_nxt = 1;
`endif
            end
            else if (m_cc) m_nxt = 1;
            else if (m_dc) m_nxt = 2;
            else m_nxt = 0;
            if (m_ec && m_ed && mcnt < CMAX) mcnt = mcnt + 1;
            mown = m_nxt;
            if (m_nxt != 0) mlast = m_nxt;
        end
    endtask

    initial forever begin
        @(posedge clk or posedge reset);
        model_step();
    end

    // every-cycle comparison of all outputs against the model
    logic [39:0] exp_v, act_v;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    initial forever begin
        @(negedge clk);
        if (chk_en && !reset) begin
            e_we = 1'b0; e_addr = '0; e_wd = '0;
            if (mown == 1) begin e_we = core_we; e_addr = core_addr; e_wd = core_wdata; end
            else if (mown == 2) begin e_we = dbg_we; e_addr = dbg_addr; e_wd = dbg_wdata; end
            exp_v = {mown == 1, mown == 2, e_we, e_addr, e_wd, m_crd, m_crv, m_drd, m_drv, CW'(mcnt)};
            act_v = {core_gnt, dbg_gnt, rf_we, rf_addr, rf_wdata, core_rdata, core_rvalid,
                     dbg_rdata, dbg_rvalid, conflict_cnt};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL model_cmp t=%0t actual=%h required=%h", $time, act_v, exp_v);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic rnd_core();
        core_req   = ($urandom_range(0, 2) != 0);
        core_we    = 1'($urandom_range(0, 1));
        core_addr  = AW'($urandom_range(0, 7));
        core_wdata = DW'($urandom);
        core_lock  = ($urandom_range(0, 5) == 0);
    endtask

    task automatic rnd_dbg();
        dbg_req   = ($urandom_range(0, 2) != 0);
        dbg_we    = 1'($urandom_range(0, 1));
        dbg_addr  = AW'($urandom_range(0, 7));
        dbg_wdata = DW'($urandom);
        dbg_lock  = ($urandom_range(0, 5) == 0);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            mreg[i] = DW'($urandom);
            phys[i] = mreg[i];
        end
        repeat (3) edge1();
        reset = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset_outs", 64'({core_gnt, dbg_gnt, rf_we, rf_addr, rf_wdata, core_rdata,
                               dbg_rdata, core_rvalid, dbg_rvalid, conflict_cnt}), 64'd0);

        // debug write reg3 = 0x5A
        edge1();
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 3'd3; dbg_wdata = 8'h5A;
        @(negedge clk);
        chk("dbg_wr_pre", 64'(dbg_gnt), 64'd0);
        edge1();
        dbg_req = 1'b0;
        @(negedge clk);
        chk("dbg_wr_gnt", 64'({dbg_gnt, rf_we, rf_addr, rf_wdata}), 64'({1'b1, 1'b1, 3'd3, 8'h5A}));
        edge1();
        @(negedge clk);
        chk("dbg_wr_end", 64'({dbg_gnt, rf_we}), 64'd0);

        // debug read reg3
        edge1();
        dbg_req = 1'b1; dbg_we = 1'b0;
        edge1();
        dbg_req = 1'b0;
        @(negedge clk);
        chk("dbg_rd_gnt", 64'(dbg_gnt), 64'd1);
        edge1();
        @(negedge clk);
        chk("dbg_rd_data", 64'({dbg_rvalid, dbg_rdata}), 64'({1'b1, 8'h5A}));
        edge1();
        @(negedge clk);
        chk("dbg_rd_hold", 64'({dbg_rvalid, dbg_rdata}), 64'({1'b0, 8'h5A}));

        // both requesters continuously: grants alternate starting with core
        edge1();
        core_req = 1'b1; core_we = 1'b0; core_addr = 3'd3;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 3'd1;
        for (int k = 1; k <= 5; k++) begin
            edge1();
            @(negedge clk);
            chk($sformatf("contend_%0d", k), 64'({core_gnt, dbg_gnt, conflict_cnt}),
                64'({(k % 2) == 1, (k % 2) == 0, CW'(k)}));
        end
        edge1();
        core_req = 1'b0; dbg_req = 1'b0;
        edge1();

        // halted core never granted; debug dumps all registers
        halt = 1'b1;
        core_req = 1'b1; core_we = 1'b1; core_addr = 3'd0; core_wdata = 8'hFF;
        for (int a = 0; a < 8; a++) begin
            edge1();
            dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = AW'(a);
            edge1();
            dbg_req = 1'b0;
            @(negedge clk);
            chk($sformatf("halt_gnt_%0d", a), 64'({core_gnt, dbg_gnt}), 64'({1'b0, 1'b1}));
            edge1();
            @(negedge clk);
            chk($sformatf("halt_dump_%0d", a), 64'({dbg_rvalid, dbg_rdata}),
                64'({1'b1, (a == 3) ? 8'h5A : mreg[a]}));
        end
        edge1();
        halt = 1'b0; core_req = 1'b0;

        // core locks for three cycles while debug waits
        edge1();
        core_req = 1'b1; core_lock = 1'b1; core_we = 1'b1; core_addr = 3'd5; core_wdata = 8'hC3;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 3'd5;
        for (int i = 1; i <= 3; i++) begin
            edge1();
            if (i == 3) begin core_lock = 1'b0; core_req = 1'b0; end
            @(negedge clk);
            chk($sformatf("lock_core_%0d", i), 64'({core_gnt, dbg_gnt}), 64'({1'b1, 1'b0}));
        end
        edge1();
        dbg_req = 1'b0;
        @(negedge clk);
        chk("lock_then_dbg", 64'({core_gnt, dbg_gnt}), 64'({1'b0, 1'b1}));
        edge1();
        @(negedge clk);
        chk("lock_readback", 64'({dbg_rvalid, dbg_rdata}), 64'({1'b1, 8'hC3}));

        // reset in the middle of a locked write burst
        edge1();
        core_req = 1'b1; core_lock = 1'b1; core_we = 1'b1; core_addr = 3'd6; core_wdata = 8'h77;
        edge1();
        @(negedge clk);
        chk("burst_gnt", 64'({core_gnt, rf_we}), 64'({1'b1, 1'b1}));
        edge1();
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset", 64'({core_gnt, dbg_gnt, rf_we, conflict_cnt}), 64'd0);
        core_req = 1'b0; core_lock = 1'b0;
        edge1();
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_cnt", 64'({core_gnt, conflict_cnt}), 64'd0);

        // counter saturation under continuous contention
        edge1();
        core_req = 1'b1; core_we = 1'b0; dbg_req = 1'b1; dbg_we = 1'b0;
        repeat (300) edge1();
        @(negedge clk);
        chk("cnt_saturate", 64'(conflict_cnt), 64'(CMAX));
        edge1();
        core_req = 1'b0; dbg_req = 1'b0;
        repeat (2) edge1();

        // randomized traffic; requests held until their grant cycle has ended
        repeat (3000) begin
            edge1();
            if (!core_req || m_cdone) rnd_core();
            if (!dbg_req || m_ddone) rnd_dbg();
            if ($urandom_range(0, 19) == 0) halt = ~halt;
        end
        edge1();
        core_req = 1'b0; dbg_req = 1'b0; core_lock = 1'b0; dbg_lock = 1'b0; halt = 1'b0;
        repeat (3) edge1();
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
